// File: rtl/alu_pkg.sv
// Shared types for the ALU execution unit: opcodes, FSM states
// and the opcode legality helper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_CMP = 4'd7,
        OP_ADC = 4'd8,
        OP_SBC = 4'd9,
        OP_MUL = 4'd10
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= 4'd10;
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// product_o is the next accumulator value; valid when done_o is high.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic               run_q;
    logic [SHW-1:0]     cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;

    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = run_q && (cnt_q == LAST);
    assign product_o = acc_d;

    // Load operands on start, then add one partial product per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// WIDTH-bit execution unit: single-cycle ALU ops, sequential multiply,
// valid/ready issue, registered result and architectural flags.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             equal_flag,
    output logic             zero_flag,
    output logic             illegal_op,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q;
    logic             ex_vld_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             equal_q;
    logic             zero_q;
    logic             out_valid_q;
    logic             illegal_q;

    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic               wr;

    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   wide;
    logic [WIDTH:0]   shr;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             ill_d;

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = ~in_ready;
    assign accept     = in_valid && in_ready;
    assign is_mul     = (alu_op_e'(op) == OP_MUL);
    assign wr         = ex_vld_q || mul_done;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign carry_flag = carry_q;
    assign equal_flag = equal_q;
    assign zero_flag  = zero_q;
    assign illegal_op = illegal_q;

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept && is_mul),
        .a_i      (a),
        .b_i      (b),
        .done_o   (mul_done),
        .product_o(mul_prod)
    );

    // Single-cycle datapath at WIDTH+1 bits; multiplier result overrides
    always_comb begin
        amt      = b_q[SHW-1:0];
        shr      = {a_q, 1'b0} >> amt;
        wide     = '0;
        carry_d  = carry_q;
        ill_d    = !is_legal_op(op_q);
        unique case (op_q)
            OP_ADD: begin
                wide    = {1'b0, a_q} + {1'b0, b_q};
                carry_d = wide[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                wide    = {1'b0, a_q} - {1'b0, b_q};
                carry_d = wide[WIDTH];
            end
            OP_AND: wide = {1'b0, a_q & b_q};
            OP_OR:  wide = {1'b0, a_q | b_q};
            OP_XOR: wide = {1'b0, a_q ^ b_q};
            OP_SHL: begin
                wide    = {1'b0, a_q} << amt;
                carry_d = wide[WIDTH];
            end
            OP_SHR: begin
                wide    = {1'b0, shr[WIDTH:1]};
                carry_d = shr[0];
            end
            OP_ADC: begin
                wide    = {1'b0, a_q} + {1'b0, b_q}
                        + {{WIDTH{1'b0}}, carry_q};
                carry_d = wide[WIDTH];
            end
            OP_SBC: begin
                wide    = {1'b0, a_q} - {1'b0, b_q}
                        - {{WIDTH{1'b0}}, carry_q};
                carry_d = wide[WIDTH];
            end
            default: wide = '0;
        endcase
        result_d = wide[WIDTH-1:0];
        if (mul_done) begin
            result_d = mul_prod[WIDTH-1:0];
            carry_d  = |mul_prod[2*WIDTH-1:WIDTH];
            ill_d    = 1'b0;
        end
    end

    // Handshake capture, FSM, and result/flag commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ex_vld_q    <= 1'b0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            equal_q     <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            ex_vld_q    <= accept && !is_mul;
            out_valid_q <= wr;
            illegal_q   <= wr && ill_d;
            if (accept) begin
                op_q <= alu_op_e'(op);
                a_q  <= a;
                b_q  <= b;
            end
            if (wr) begin
                result_q <= result_d;
                if (!ill_d) begin
                    carry_q <= carry_d;
                    equal_q <= (a_q == b_q);
                    zero_q  <= (result_d == '0);
                end
            end
            unique case (state_q)
                ST_IDLE: if (accept && is_mul) state_q <= ST_MUL;
                ST_MUL:  if (mul_done) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (WIDTH=8) plus a WIDTH=16
// instance for the wide carry-out case.
module tb_alu_exec_unit;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       e;
        logic       z;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       in_ready, out_valid, carry_flag, equal_flag;
    logic       zero_flag, illegal_op, busy;
    logic [7:0] result;

    logic        in_valid16 = 1'b0;
    logic [3:0]  op16 = 4'd0;
    logic [15:0] a16 = 16'd0;
    logic [15:0] b16 = 16'd0;
    logic        in_ready16, out_valid16, carry16, equal16;
    logic        zero16, illegal16, busy16;
    logic [15:0] result16;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic m_c = 1'b0;
    logic m_e = 1'b0;
    logic m_z = 1'b0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .result(result),
        .carry_flag(carry_flag), .equal_flag(equal_flag),
        .zero_flag(zero_flag), .illegal_op(illegal_op), .busy(busy)
    );

    alu_exec_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16),
        .in_ready(in_ready16), .op(op16), .a(a16), .b(b16),
        .out_valid(out_valid16), .result(result16),
        .carry_flag(carry16), .equal_flag(equal16),
        .zero_flag(zero16), .illegal_op(illegal16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o,
                                   input logic [7:0] x,
                                   input logic [7:0] y);
        exp_t        e;
        logic [31:0] xi, yi, s;
        int          n;
        xi = {24'd0, x};
        yi = {24'd0, y};
        n = int'(y & 8'd7);
        s = '0;
        e.c = m_c;
        e.ill = 1'b0;
        case (o)
            4'd0: begin s = xi + yi; e.c = s[8]; end
            4'd1, 4'd7: begin s = xi - yi; e.c = (xi < yi); end
            4'd2: s = xi & yi;
            4'd3: s = xi | yi;
            4'd4: s = xi ^ yi;
            4'd5: begin
                s = xi << n;
                e.c = (n == 0) ? 1'b0 : s[8];
            end
            4'd6: begin
                s = xi >> n;
                e.c = (n == 0) ? 1'b0 : xi[n-1];
            end
            4'd8: begin s = xi + yi + {31'd0, m_c}; e.c = s[8]; end
            4'd9: begin
                s = xi - yi - {31'd0, m_c};
                e.c = (xi < yi + {31'd0, m_c});
            end
            4'd10: begin s = xi * yi; e.c = (s[15:8] != 8'd0); end
            default: begin s = '0; e.ill = 1'b1; end
        endcase
        e.r = s[7:0];
        if (e.ill) begin
            e.e = m_e;
            e.z = m_z;
        end else begin
            e.e = (x == y);
            e.z = (e.r == 8'd0);
        end
        return e;
    endfunction

    task automatic push(input logic [3:0] o, input logic [7:0] x,
                        input logic [7:0] y);
        exp_t e;
        e = model(o, x, y);
        m_c = e.c;
        m_e = e.e;
        m_z = e.z;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] x,
                         input logic [7:0] y);
        int t = 0;
        while (!in_ready && t < 64) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 64) check("rdy_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        push(o, x, y);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag, input int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        check(tag, n, lat);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.r);
                check("carry", carry_flag, e.c);
                check("equal", equal_flag, e.e);
                check("zero", zero_flag, e.z);
                check("illegal", illegal_op, e.ill);
            end
        end
        if (!rst && illegal_op && !out_valid)
            check("ill_no_valid", 32'd1, 32'd0);
    end

    initial begin
        int busy_n, n, cnt;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_flags", {carry_flag, equal_flag, zero_flag}, 32'd0);
        check("rst_valid", {out_valid, illegal_op}, 32'd0);
        check("rst_ready", {in_ready, busy}, 32'd2);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(4'd0, 8'hF0, 8'h20);
        wait_out("add_latency", 2);
        drain();

        issue(4'd0, 8'hFF, 8'h01);
        issue(4'd8, 8'h01, 8'h01);
        drain();

        issue(4'd1, 8'h05, 8'h07);
        issue(4'd7, 8'h42, 8'h42);
        drain();

        issue(4'd10, 8'h10, 8'h11);
        in_valid = 1'b1;
        op = 4'd0;
        a = 8'h01;
        b = 8'h02;
        busy_n = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!in_ready) busy_n++;
            if (n == 3) in_valid = 1'b0;
        end while (!out_valid && n < 40);
        check("mul_latency", n, 32'd9);
        check("mul_busy_cycles", busy_n, 32'd8);
        drain();

        issue(4'd10, 8'h37, 8'h5B);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_c = 1'b0;
        m_e = 1'b0;
        m_z = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_flags", {carry_flag, equal_flag, zero_flag}, 32'd0);
        check("abort_ready", in_ready, 32'd1);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("abort_no_out", cnt, 32'd0);
        @(posedge clk);
        #1;

        issue(4'd5, 8'h81, 8'h01);
        issue(4'd5, 8'h81, 8'h00);
        issue(4'd6, 8'h81, 8'h01);
        drain();

        issue(4'd0, 8'hFF, 8'h01);
        issue(4'd15, 8'h12, 8'h34);
        drain();
        check("ill_keeps_carry", carry_flag, 32'd1);

        for (int i = 0; i < 40; i++) begin
            issue(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
        end
        drain();

        in_valid16 = 1'b1;
        op16 = 4'd0;
        a16 = 16'hFFFF;
        b16 = 16'h0001;
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid16 && n < 20);
        check("w16_latency", n, 32'd2);
        check("w16_result", result16, 32'd0);
        check("w16_flags", {carry16, zero16, equal16, illegal16},
              32'b1100);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
